// File: rtl/cat_rec_pkg.sv
// Shared FSM encoding, APB register map and CTRL/STATUS bit positions
// for the cat recognizer control core.
package cat_rec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_EVAL,
        S_CAPTURE
    } state_t;

    localparam int CTRL_ADDR  = 0;
    localparam int STAT_ADDR  = 1;
    localparam int PIX_BASE   = 2;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_RESULT  = 2;

endpackage

// File: rtl/cat_rec_apb_if.sv
// APB slave decode: CTRL command pulses, pixel write detection and the
// combinational STATUS read mux. Zero wait states.
module cat_rec_apb_if
    import cat_rec_pkg::*;
#(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int Num_Pixels      = 3072
) (
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic [Amba_Word-1:0]       PWDATA,
    input  logic                       i_busy,
    input  logic                       i_done,
    input  logic                       i_result,
    output logic                       o_start,
    output logic                       o_abort,
    output logic                       o_pix_wr,
    output logic [Amba_Addr_Depth-1:0] o_pix_addr,
    output logic [Amba_Word-1:0]       PRDATA
);

    localparam logic [Amba_Addr_Depth-1:0] L_CTRL      = Amba_Addr_Depth'(CTRL_ADDR);
    localparam logic [Amba_Addr_Depth-1:0] L_STAT      = Amba_Addr_Depth'(STAT_ADDR);
    localparam logic [Amba_Addr_Depth-1:0] L_PIX_FIRST = Amba_Addr_Depth'(PIX_BASE);
    localparam logic [Amba_Addr_Depth-1:0] L_PIX_LAST  = Amba_Addr_Depth'(PIX_BASE + Num_Pixels - 1);

    logic w_access;
    logic w_wr;
    logic w_rd;

    assign w_access   = PSEL & PENABLE;
    assign w_wr       = w_access & PWRITE;
    assign w_rd       = w_access & ~PWRITE;

    assign o_start    = w_wr && (PADDR == L_CTRL) && PWDATA[CTRL_START];
    assign o_abort    = w_wr && (PADDR == L_CTRL) && PWDATA[CTRL_ABORT];
    assign o_pix_wr   = w_wr && (PADDR >= L_PIX_FIRST) && (PADDR <= L_PIX_LAST);
    assign o_pix_addr = PADDR - L_PIX_FIRST;

    // Only STATUS is readable; CTRL, pixels and holes all read as zero.
    always_comb begin
        PRDATA = '0;
        if (w_rd && (PADDR == L_STAT)) begin
            PRDATA[ST_BUSY]   = i_busy;
            PRDATA[ST_DONE]   = i_done;
            PRDATA[ST_RESULT] = i_result;
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Control core of the cat recognizer: loads pixels over APB, then walks
// pixel/weight memory once per inference and latches the verdict.
module neuron_sequencer
    import cat_rec_pkg::*;
#(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int Num_Pixels      = 3072
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    output logic                       PREADY,
    output logic [Amba_Addr_Depth-1:0] mem_addr,
    output logic                       mem_wr_en,
    output logic                       mem_rd_en,
    output logic                       acc_clear,
    output logic                       acc_en,
    output logic                       get_result,
    input  logic                       calc_out,
    output logic                       busy,
    output logic                       CatRecOut
);

    localparam logic [Amba_Addr_Depth-1:0] L_LAST_IDX = Amba_Addr_Depth'(Num_Pixels - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [Amba_Addr_Depth-1:0]  r_idx;
    logic                        r_acc_en;
    logic                        r_done;
    logic                        r_result;

    logic                        w_start_req;
    logic                        w_abort_req;
    logic                        w_pix_wr;
    logic [Amba_Addr_Depth-1:0]  w_pix_addr;
    logic                        w_idle;
    logic                        w_start;
    logic                        w_abort;

    cat_rec_apb_if #(
        .Amba_Word       (Amba_Word),
        .Amba_Addr_Depth (Amba_Addr_Depth),
        .Num_Pixels      (Num_Pixels)
    ) u_apb (
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .i_busy     (busy),
        .i_done     (r_done),
        .i_result   (r_result),
        .o_start    (w_start_req),
        .o_abort    (w_abort_req),
        .o_pix_wr   (w_pix_wr),
        .o_pix_addr (w_pix_addr),
        .PRDATA     (PRDATA)
    );

    assign PREADY    = 1'b1;
    assign w_idle    = (r_state == S_IDLE);
    // Abort beats start when both bits arrive in one write.
    assign w_start   = w_start_req & ~w_abort_req & w_idle;
    assign w_abort   = w_abort_req & ~w_idle;
    assign acc_en    = r_acc_en;
    assign CatRecOut = r_result;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) w_next = S_CLEAR;
                S_CLEAR:   w_next = S_FETCH;
                S_FETCH:   if (r_idx == L_LAST_IDX) w_next = S_DRAIN;
                S_DRAIN:   w_next = S_EVAL;
                S_EVAL:    w_next = S_CAPTURE;
                S_CAPTURE: w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = ~w_idle;
        acc_clear  = (r_state == S_CLEAR);
        mem_rd_en  = (r_state == S_FETCH);
        get_result = (r_state == S_EVAL);
        mem_wr_en  = w_idle & w_pix_wr;
        mem_addr   = '0;
        if (mem_rd_en)      mem_addr = r_idx;
        else if (mem_wr_en) mem_addr = w_pix_addr;
    end

    // acc_en trails mem_rd_en by one cycle, matching memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_acc_en <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_acc_en <= mem_rd_en & ~w_abort;
            if (r_state == S_CLEAR)      r_idx <= '0;
            else if (r_state == S_FETCH) r_idx <= r_idx + 1'b1;
            if (w_start) r_done <= 1'b0;
            if ((r_state == S_CAPTURE) && !w_abort) begin
                r_done   <= 1'b1;
                r_result <= calc_out;
            end
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer with a 4-pixel image: stimulus queues
// timed expected events, a negedge monitor matches them against DUT strobes.
module tb_neuron_sequencer;

    localparam int AW = 24;
    localparam int AD = 12;
    localparam int NP = 4;

    localparam int K_WR = 0, K_RD = 1, K_ACC = 2, K_CLR = 3, K_GR = 4, K_PRD = 5, K_BUSY = 6, K_CRO = 7;
    localparam int NK = 8;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          PSEL, PENABLE, PWRITE;
    logic [AD-1:0] PADDR;
    logic [AW-1:0] PWDATA;
    logic [AW-1:0] PRDATA;
    logic          PREADY;
    logic [AD-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en, acc_clear, acc_en, get_result;
    logic          calc_out, busy, CatRecOut;

    ev_t q[$];
    int  cyc    = 0;
    int  n_vec  = 0;
    int  n_err  = 0;
    string kname [NK] = '{"mem_wr", "mem_rd", "acc_en", "acc_clear", "get_result", "prdata", "busy", "catrecout"};

    neuron_sequencer #(
        .Amba_Word       (AW),
        .Amba_Addr_Depth (AD),
        .Num_Pixels      (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .get_result (get_result),
        .calc_out   (calc_out),
        .busy       (busy),
        .CatRecOut  (CatRecOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int k, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        q.push_back(e);
    endtask

    // Monitor: strobe kinds must match the queue exactly; level kinds are checked only when expected.
    always @(negedge clk) begin
        logic s;
        int   v;
        int   idx;
        for (int k = 0; k < NK; k++) begin
            s = 1'b0; v = 0;
            case (k)
                K_WR:    begin s = mem_wr_en;  v = int'(mem_addr); end
                K_RD:    begin s = mem_rd_en;  v = int'(mem_addr); end
                K_ACC:   s = acc_en;
                K_CLR:   s = acc_clear;
                K_GR:    s = get_result;
                K_PRD:   begin s = PSEL && PENABLE && !PWRITE; v = int'(PRDATA); end
                K_BUSY:  begin s = 1'b1; v = int'(busy); end
                default: begin s = 1'b1; v = int'(CatRecOut); end
            endcase
            idx = -1;
            foreach (q[i]) if (idx < 0 && q[i].cyc == cyc && q[i].kind == k) idx = i;
            if (idx >= 0) begin
                n_vec++;
                if (!s || v != q[idx].val) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: got strobe=%0b val=%0d, expected strobe=1 val=%0d",
                             kname[k], cyc, s, v, q[idx].val);
                end
                q.delete(idx);
            end else if (k < K_BUSY && s) begin
                n_vec++;
                n_err++;
                $display("FAIL %s cycle %0d: unexpected strobe val=%0d, expected none", kname[k], cyc, v);
            end
        end
    end

    task automatic apb_write(input int a, input int d, input int exp_wr, output int c);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AD'(a); PWDATA = AW'(d);
        @(posedge clk); #1;
        PENABLE = 1'b1;
        c = cyc;
        if (exp_wr >= 0) push(c, K_WR, exp_wr);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input int a, input int exp_val);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AD'(a);
        @(posedge clk); #1;
        PENABLE = 1'b1;
        push(cyc, K_PRD, exp_val);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Full pass timeline for a start write whose access cycle is c.
    task automatic push_pass(input int c, input int r);
        push(c + 1, K_CLR, 0);
        push(c + 1, K_BUSY, 1);
        for (int i = 0; i < NP; i++) begin
            push(c + 2 + i, K_RD, i);
            push(c + 3 + i, K_ACC, 0);
        end
        push(c + NP + 3, K_GR, 0);
        push(c + NP + 4, K_BUSY, 1);
        push(c + NP + 5, K_BUSY, 0);
        push(c + NP + 5, K_CRO, r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2;
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; calc_out = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset state and zero reads
        push(cyc + 1, K_BUSY, 0);
        push(cyc + 1, K_CRO, 0);
        apb_read(1, 0);
        apb_read(0, 0);
        apb_read(2, 0);

        // Pixel loads, out-of-range pixel, CTRL without start
        for (int k = 0; k < NP; k++) apb_write(2 + k, 16 + k, k, c);
        apb_write(NP + 2, 99, -1, c);
        apb_write(0, 0, -1, c);

        // Full pass, verdict 1
        calc_out = 1'b1;
        apb_write(0, 1, -1, c);
        push_pass(c, 1);
        idle(NP + 5);
        apb_read(1, 6);

        // Pixel write and start during FETCH are ignored
        calc_out = 1'b0;
        apb_write(0, 1, -1, c);
        push_pass(c, 0);
        apb_write(3, 55, -1, c2);
        apb_write(0, 1, -1, c2);
        idle(4);
        apb_read(1, 2);
        calc_out = 1'b1;
        apb_write(0, 1, -1, c);
        push_pass(c, 1);
        idle(NP + 5);
        apb_read(1, 6);

        // Abort mid-FETCH; then start+abort in IDLE does nothing
        apb_write(0, 1, -1, c);
        push(c + 1, K_CLR, 0);
        push(c + 2, K_RD, 0);
        push(c + 3, K_RD, 1);
        push(c + 3, K_ACC, 0);
        apb_write(0, 2, -1, c2);
        push(c2 + 1, K_BUSY, 0);
        push(c2 + 1, K_CRO, 1);
        idle(3);
        apb_read(1, 4);
        apb_write(0, 3, -1, c2);
        push(c2 + 1, K_BUSY, 0);
        idle(3);
        apb_read(1, 4);

        // Reset mid-FETCH, then a clean pass
        apb_write(0, 1, -1, c);
        push(c + 1, K_CLR, 0);
        push(c + 2, K_RD, 0);
        push(c + 3, K_RD, 1);
        push(c + 3, K_ACC, 0);
        push(c + 4, K_BUSY, 0);
        push(c + 4, K_CRO, 0);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        apb_read(1, 0);
        apb_write(0, 1, -1, c);
        push_pass(c, 1);
        idle(NP + 5);
        apb_read(1, 6);

        idle(5);
        foreach (q[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s cycle %0d: event never checked, expected val=%0d", kname[q[i].kind], q[i].cyc, q[i].val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
